// File: rtl/fofb_coef_sequencer_pkg.sv
// Shared constants for the FOFB coefficient sequencer: op codes and FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fofb_coef_sequencer_pkg;

    // Command op codes as presented on cmdOp
    localparam logic [1:0] OP_MATX       = 2'd0;
    localparam logic [1:0] OP_MATY       = 2'd1;
    localparam logic [1:0] OP_FIR_RELOAD = 2'd2;
    localparam logic [1:0] OP_FIR_CONFIG = 2'd3;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/fofb_coef_sequencer.sv
// Copies host-buffer words into FOFB coefficient DPRAMs / FIR reload / FIR config, one word at a time.
// Latency: accept to first strobe 3 cycles, then 3 cycles per word minimum; done 1 cycle after last strobe.
// Backpressure: cmdReady only in IDLE; each word waits in WAIT on its gate (calcBusy / FIR busy) up to TIMEOUT_CYCLES.
module fofb_coef_sequencer
    import fofb_coef_sequencer_pkg::*;
#(
    parameter int RESULT_COUNT        = 1,
    parameter int COEF_ROWS_WIDTH     = (RESULT_COUNT > 1) ? $clog2(RESULT_COUNT) : 1,
    parameter int MATRIX_COLUMN_WIDTH = 9,
    parameter int COEFFICIENT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES      = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmdValid,
    output logic                           cmdReady,
    input  logic [1:0]                     cmdOp,
    input  logic [COEF_ROWS_WIDTH-1:0]     cmdRow,
    input  logic [MATRIX_COLUMN_WIDTH:0]   cmdCount,
    output logic [MATRIX_COLUMN_WIDTH-1:0] srcAddr,
    input  logic [COEFFICIENT_WIDTH-1:0]   srcData,
    input  logic                           calcBusy,
    input  logic                           firReloadBusy,
    input  logic                           firConfigBusy,
    output logic                           coefficientWriteStrobe,
    output logic                           firReloadStrobe,
    output logic                           firConfigStrobe,
    output logic [COEF_ROWS_WIDTH-1:0]     coefficientWriteRow,
    output logic                           coefficientWritePlane,
    output logic [MATRIX_COLUMN_WIDTH-1:0] coefficientWriteColumn,
    output logic [COEFFICIENT_WIDTH-1:0]   coefficientWriteValue,
    output logic                           busy,
    output logic                           done,
    output logic                           errTimeout,
    output logic                           errCount
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MATRIX_COLUMN_WIDTH:0] CNT_ONE   = 1;
    localparam logic [MATRIX_COLUMN_WIDTH:0] CNT_MAX   = {1'b1, {MATRIX_COLUMN_WIDTH{1'b0}}};
    localparam logic [TW-1:0]                WAIT_ONE  = 1;
    localparam logic [TW-1:0]                WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]                     r_state;
    logic [1:0]                     r_op;
    logic [COEF_ROWS_WIDTH-1:0]     r_row;
    logic [MATRIX_COLUMN_WIDTH:0]   r_count;
    logic [MATRIX_COLUMN_WIDTH:0]   r_index;
    logic [TW-1:0]                  r_wait_cnt;
    logic [COEF_ROWS_WIDTH-1:0]     r_wr_row;
    logic                           r_wr_plane;
    logic [MATRIX_COLUMN_WIDTH-1:0] r_wr_column;
    logic [COEFFICIENT_WIDTH-1:0]   r_wr_value;
    logic                           r_err_timeout;
    logic                           r_err_count;

    logic w_gate_open;
    logic w_last;
    logic w_plane;

    // Per-op gate, last-word detect and plane bit for the word currently held in WAIT
    always_comb begin
        w_gate_open = 1'b0;
        w_plane     = 1'b0;
        // Config always moves exactly one word whatever the count says
        w_last      = (r_op == OP_FIR_CONFIG) || (r_index == (r_count - CNT_ONE));
        case (r_op)
            OP_MATX, OP_MATY: begin
                w_gate_open = !calcBusy;
                w_plane     = r_op[0];
            end
            OP_FIR_RELOAD: begin
                w_gate_open = !firReloadBusy;
                w_plane     = w_last;           // TLAST on the final reload word
            end
            default: begin
                w_gate_open = !firConfigBusy;
                w_plane     = 1'b0;
            end
        endcase
    end

    // Command FSM; write fields are captured on WAIT->WRITE so they hold until the next WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_MATX;
            r_row         <= '0;
            r_count       <= '0;
            r_index       <= '0;
            r_wait_cnt    <= '0;
            r_wr_row      <= '0;
            r_wr_plane    <= 1'b0;
            r_wr_column   <= '0;
            r_wr_value    <= '0;
            r_err_timeout <= 1'b0;
            r_err_count   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmdValid) begin
                        r_op          <= cmdOp;
                        r_row         <= cmdRow;
                        r_count       <= cmdCount;
                        r_index       <= '0;
                        r_err_timeout <= 1'b0;
                        r_err_count   <= 1'b0;
                        if (cmdCount == '0) begin
                            r_state <= ST_DONE;
                        end else if (cmdCount > CNT_MAX) begin
                            r_err_count <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_gate_open) begin
                        r_wr_row    <= r_row;
                        r_wr_plane  <= w_plane;
                        r_wr_column <= r_index[MATRIX_COLUMN_WIDTH-1:0];
                        r_wr_value  <= srcData;
                        r_state     <= ST_WRITE;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // Abandon the command; words already written stay written
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                    end
                end
                ST_WRITE: begin
                    r_index <= r_index + CNT_ONE;
                    r_state <= w_last ? ST_DONE : ST_READ;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and status decode straight from the state register so reset kills them at once
    assign coefficientWriteStrobe = (r_state == ST_WRITE) && !r_op[1];
    assign firReloadStrobe        = (r_state == ST_WRITE) && (r_op == OP_FIR_RELOAD);
    assign firConfigStrobe        = (r_state == ST_WRITE) && (r_op == OP_FIR_CONFIG);
    assign cmdReady               = (r_state == ST_IDLE);
    assign busy                   = (r_state != ST_IDLE);
    assign done                   = (r_state == ST_DONE);
    assign srcAddr                = r_index[MATRIX_COLUMN_WIDTH-1:0];
    assign coefficientWriteRow    = r_wr_row;
    assign coefficientWritePlane  = r_wr_plane;
    assign coefficientWriteColumn = r_wr_column;
    assign coefficientWriteValue  = r_wr_value;
    assign errTimeout             = r_err_timeout;
    assign errCount               = r_err_count;

endmodule

// File: tb/tb_fofb_coef_sequencer.sv
// Directed bench for fofb_coef_sequencer: matrix, FIR reload/config, gating, errors, reset.
// Latency: n/a.
// Backpressure: drives gates directly.
module tb_fofb_coef_sequencer;
    import fofb_coef_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [0:0]  cmdRow;
    logic [9:0]  cmdCount;
    logic [8:0]  srcAddr;
    logic [31:0] srcData;
    logic        calcBusy, firReloadBusy, firConfigBusy;
    logic        coefficientWriteStrobe, firReloadStrobe, firConfigStrobe;
    logic [0:0]  coefficientWriteRow;
    logic        coefficientWritePlane;
    logic [8:0]  coefficientWriteColumn;
    logic [31:0] coefficientWriteValue;
    logic        busy, done, errTimeout, errCount;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] mem [0:511];

    // Strobe log, recorded at the falling edge
    int          ev_kind[$];
    int          ev_col[$];
    int          ev_row[$];
    int          ev_cyc[$];
    logic        ev_plane[$];
    logic [31:0] ev_val[$];

    fofb_coef_sequencer #(
        .RESULT_COUNT(2), .MATRIX_COLUMN_WIDTH(9), .COEFFICIENT_WIDTH(32), .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdRow(cmdRow), .cmdCount(cmdCount),
        .srcAddr(srcAddr), .srcData(srcData),
        .calcBusy(calcBusy), .firReloadBusy(firReloadBusy), .firConfigBusy(firConfigBusy),
        .coefficientWriteStrobe(coefficientWriteStrobe), .firReloadStrobe(firReloadStrobe),
        .firConfigStrobe(firConfigStrobe), .coefficientWriteRow(coefficientWriteRow),
        .coefficientWritePlane(coefficientWritePlane), .coefficientWriteColumn(coefficientWriteColumn),
        .coefficientWriteValue(coefficientWriteValue),
        .busy(busy), .done(done), .errTimeout(errTimeout), .errCount(errCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous source buffer: data one cycle after address
    always @(posedge clk) srcData <= mem[srcAddr];

    task automatic log_ev(input int k);
        ev_kind.push_back(k);
        ev_col.push_back(int'(coefficientWriteColumn));
        ev_row.push_back(int'(coefficientWriteRow));
        ev_cyc.push_back(cyc);
        ev_plane.push_back(coefficientWritePlane);
        ev_val.push_back(coefficientWriteValue);
    endtask

    always @(negedge clk) begin
        if (coefficientWriteStrobe) log_ev(0);
        if (firReloadStrobe)        log_ev(1);
        if (firConfigStrobe)        log_ev(2);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ev_chk(input string t, input int idx, input int kind, input logic plane,
                          input int col, input logic [31:0] val, input int c, input int row);
        if (idx < ev_kind.size()) begin
            chk({t, "_kind"},  ev_kind[idx],  kind);
            chk({t, "_plane"}, ev_plane[idx], plane);
            chk({t, "_col"},   ev_col[idx],   col);
            chk({t, "_val"},   ev_val[idx],   val);
            chk({t, "_cyc"},   ev_cyc[idx],   c);
            chk({t, "_row"},   ev_row[idx],   row);
        end else begin
            chk({t, "_present"}, 0, 1);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [0:0] row, input logic [9:0] cnt,
                         output int acc);
        @(posedge clk); #1;
        cmdValid = 1'b1; cmdOp = op; cmdRow = row; cmdCount = cnt;
        @(negedge clk) acc = cyc;
        @(posedge clk); #1;
        cmdValid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dc);
        dc = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        chk("done_seen", (dc >= 0), 1);
    endtask

    initial begin
        int acc, dc, base, ndone;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        rst_n = 1'b0; cmdValid = 1'b0; cmdOp = 2'd0; cmdRow = 1'b0; cmdCount = 10'd0;
        calcBusy = 1'b0; firReloadBusy = 1'b0; firConfigBusy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmdReady", cmdReady, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {coefficientWriteStrobe, firReloadStrobe, firConfigStrobe}, 0);
        chk("rst_srcAddr", srcAddr, 0);
        chk("rst_errs", {errTimeout, errCount}, 0);
        chk("rst_value", coefficientWriteValue, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Matrix X, 3 words, gate open
        mem[0] = 32'd10; mem[1] = 32'd20; mem[2] = 32'd30;
        base = ev_kind.size();
        issue(OP_MATX, 1'b0, 10'd3, acc);
        wait_done(100, dc);
        chk("t1_done_cyc", dc, acc + 10);
        chk("t1_ready_in_done", cmdReady, 0);
        @(negedge clk);
        chk("t1_ready_after", cmdReady, 1);
        chk("t1_done_pulse", done, 0);
        chk("t1_nev", ev_kind.size() - base, 3);
        for (int i = 0; i < 3; i++)
            ev_chk($sformatf("t1_w%0d", i), base + i, 0, 1'b0, i, 32'd10 * (i + 1), acc + 3 + 3 * i, 0);
        chk("t1_errCount", errCount, 0);

        // Matrix Y, 2 words, row 1, calcBusy held 20 cycles after accept
        mem[0] = 32'h11; mem[1] = 32'h22;
        calcBusy = 1'b1;
        base = ev_kind.size();
        issue(OP_MATY, 1'b1, 10'd2, acc);
        repeat (19) @(posedge clk);
        chk("t2_stall_nev", ev_kind.size() - base, 0);
        #1 calcBusy = 1'b0;
        wait_done(100, dc);
        chk("t2_done_cyc", dc, acc + 25);
        @(negedge clk);
        chk("t2_nev", ev_kind.size() - base, 2);
        ev_chk("t2_w0", base,     0, 1'b1, 0, 32'h11, acc + 21, 1);
        ev_chk("t2_w1", base + 1, 0, 1'b1, 1, 32'h22, acc + 24, 1);

        // FIR reload, 4 words, busy pulse of 5 cycles starting with word 2's strobe
        mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
        base = ev_kind.size();
        issue(OP_FIR_RELOAD, 1'b0, 10'd4, acc);
        repeat (5) @(posedge clk);
        #1 firReloadBusy = 1'b1;
        repeat (5) @(posedge clk);
        #1 firReloadBusy = 1'b0;
        wait_done(100, dc);
        chk("t3_done_cyc", dc, acc + 16);
        @(negedge clk);
        chk("t3_nev", ev_kind.size() - base, 4);
        ev_chk("t3_w0", base,     1, 1'b0, 0, 32'hA0, acc + 3,  0);
        ev_chk("t3_w1", base + 1, 1, 1'b0, 1, 32'hA1, acc + 6,  0);
        ev_chk("t3_w2", base + 2, 1, 1'b0, 2, 32'hA2, acc + 12, 0);
        ev_chk("t3_w3", base + 3, 1, 1'b1, 3, 32'hA3, acc + 15, 0);

        // FIR config, count 7 -> one word only
        mem[0] = 32'h05;
        base = ev_kind.size();
        issue(OP_FIR_CONFIG, 1'b0, 10'd7, acc);
        wait_done(100, dc);
        chk("t4_done_cyc", dc, acc + 4);
        @(negedge clk);
        chk("t4_nev", ev_kind.size() - base, 1);
        ev_chk("t4_w0", base, 2, 1'b0, 0, 32'h05, acc + 3, 0);
        chk("t4_val_lo", coefficientWriteValue[7:0], 8'd5);

        // Oversized count: error, no strobes
        base = ev_kind.size();
        issue(OP_MATX, 1'b0, 10'd513, acc);
        wait_done(20, dc);
        chk("t5_done_cyc", dc, acc + 1);
        chk("t5_errCount", errCount, 1);
        @(negedge clk);
        chk("t5_errCount_sticky", errCount, 1);
        chk("t5_nev", ev_kind.size() - base, 0);

        // Zero count: immediate done, sticky error cleared on accept
        issue(OP_MATX, 1'b0, 10'd0, acc);
        chk("t5z_errCount_clr", errCount, 0);
        wait_done(20, dc);
        chk("t5z_done_cyc", dc, acc + 1);
        chk("t5z_nev", ev_kind.size() - base, 0);

        // Reload with busy stuck high -> timeout
        firReloadBusy = 1'b1;
        issue(OP_FIR_RELOAD, 1'b0, 10'd2, acc);
        wait_done(5000, dc);
        chk("t5t_done_cyc", dc, acc + 4098);
        chk("t5t_errTimeout", errTimeout, 1);
        chk("t5t_errCount", errCount, 0);
        @(negedge clk);
        chk("t5t_nev", ev_kind.size() - base, 0);
        firReloadBusy = 1'b0;

        // Reset during the third strobe of an 8-word command
        for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
        base = ev_kind.size();
        issue(OP_MATX, 1'b0, 10'd8, acc);
        chk("t6_errTimeout_clr", errTimeout, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("t6_pre_strobe", coefficientWriteStrobe, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_strobe_drop", {coefficientWriteStrobe, firReloadStrobe, firConfigStrobe}, 0);
        chk("t6_busy_drop", busy, 0);
        chk("t6_ready_rst", cmdReady, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("t6_no_done", ndone, 0);
        chk("t6_nev", ev_kind.size() - base, 2);
        chk("t6_ready_after", cmdReady, 1);
        chk("t6_busy_after", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
